// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: lw load-use interlock plus a one-entry scoreboard for multi-cycle mult/div.
// Optional stall statistics counters are built when STALL_STATS_EN is defined.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6,
    parameter int STAT_W     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           fd_insn,
    input  logic [31:0]           dx_insn,
    input  logic                  dx_valid,
    input  logic                  flush,
    input  logic                  md_ready,
    output logic                  stall,
    output logic                  md_busy,
    output logic [REG_ADDR_W-1:0] md_pending_rd,
    output logic                  md_timeout
`ifdef STALL_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_load_use,
    output logic [STAT_W-1:0]     stat_md
`endif
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic is_muldiv(input logic [31:0] insn);
        return (insn[31:27] == OP_RTYPE) &&
               ((insn[6:2] == ALU_MUL) || (insn[6:2] == ALU_DIV));
    endfunction

    // sw_bypass drops the sw data register from the source set (it is forwarded at M).
    function automatic logic reads_reg(input logic [31:0] insn,
                                       input logic [REG_ADDR_W-1:0] r,
                                       input logic sw_bypass);
        logic rs_used;
        logic rt_used;
        logic rd_used;
        rs_used = 1'b0;
        rt_used = 1'b0;
        rd_used = 1'b0;
        case (insn[31:27])
            OP_RTYPE: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            OP_ADDI, OP_LW: rs_used = 1'b1;
            OP_SW: begin
                rs_used = 1'b1;
                rd_used = !sw_bypass;
            end
            OP_BNE, OP_BLT: begin
                rs_used = 1'b1;
                rd_used = 1'b1;
            end
            OP_JR: rd_used = 1'b1;
            default: rs_used = 1'b0;
        endcase
        return (r != REG_ZERO) &&
               ((rs_used && (insn[17 +: REG_ADDR_W] == r)) ||
                (rt_used && (insn[12 +: REG_ADDR_W] == r)) ||
                (rd_used && (insn[22 +: REG_ADDR_W] == r)));
    endfunction

    function automatic logic writes_reg(input logic [31:0] insn,
                                        input logic [REG_ADDR_W-1:0] r);
        logic hit;
        case (insn[31:27])
            OP_RTYPE, OP_ADDI, OP_LW: hit = (insn[22 +: REG_ADDR_W] == r);
            OP_JAL:                   hit = (r == REG_ADDR_W'(31));
            OP_SETX:                  hit = (r == REG_ADDR_W'(30));
            default:                  hit = 1'b0;
        endcase
        return (r != REG_ZERO) && hit;
    endfunction

    logic [0:0]            state_r;
    logic [0:0]            state_nx_s;
    logic [REG_ADDR_W-1:0] pend_r;
    logic [REG_ADDR_W-1:0] pend_nx_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nx_s;
    logic                  timeout_r;
    logic                  timeout_nx_s;

    logic [REG_ADDR_W-1:0] dx_rd_s;
    logic                  load_use_s;
    logic                  md_hit_s;
    logic                  issue_s;
    logic                  busy_s;

    assign dx_rd_s    = dx_insn[22 +: REG_ADDR_W];
    assign busy_s     = (state_r == ST_BUSY);
    assign load_use_s = dx_valid && (dx_insn[31:27] == OP_LW) && (dx_rd_s != REG_ZERO) &&
                        reads_reg(fd_insn, dx_rd_s, 1'b1);
    // Scoreboard term looks only at registered state, so md_ready takes effect one cycle late.
    assign md_hit_s   = busy_s && (reads_reg(fd_insn, pend_r, 1'b0) ||
                                   writes_reg(fd_insn, pend_r) ||
                                   is_muldiv(fd_insn));
    assign stall      = !reset && (load_use_s || md_hit_s);
    assign issue_s    = dx_valid && !flush && !stall && is_muldiv(dx_insn) && (dx_rd_s != REG_ZERO);

    assign md_busy       = busy_s;
    assign md_pending_rd = pend_r;
    assign md_timeout    = timeout_r;

    // Scoreboard next-state: allocate on issue, retire on writeback or watchdog expiry.
    always_comb begin
        state_nx_s   = state_r;
        pend_nx_s    = pend_r;
        cnt_nx_s     = cnt_r;
        timeout_nx_s = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_nx_s = ST_BUSY;
                    pend_nx_s  = dx_rd_s;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_ready) begin
                    state_nx_s = ST_IDLE;
                    pend_nx_s  = REG_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s   = ST_IDLE;
                    pend_nx_s    = REG_ZERO;
                    timeout_nx_s = 1'b1;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                pend_nx_s  = REG_ZERO;
            end
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pend_r    <= REG_ZERO;
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pend_r    <= pend_nx_s;
            cnt_r     <= cnt_nx_s;
            timeout_r <= timeout_nx_s;
        end
    end

`ifdef STALL_STATS_EN
    // Stall cycle counters; a cycle with both causes bumps both.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_load_use <= {STAT_W{1'b0}};
            stat_md       <= {STAT_W{1'b0}};
        end else begin
            if (load_use_s) begin
                stat_load_use <= stat_load_use + STAT_W'(1);
            end else begin
                stat_load_use <= stat_load_use;
            end
            if (md_hit_s) begin
                stat_md <= stat_md + STAT_W'(1);
            end else begin
                stat_md <= stat_md;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: load-use vector table, directed scoreboard sequences,
// and randomized traffic against a behavioural model.
module tb_hazard_scoreboard;
    localparam int MD_TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_insn;
    logic [31:0] dx_insn;
    logic        dx_valid;
    logic        flush;
    logic        md_ready;
    logic        stall;
    logic        md_busy;
    logic [4:0]  md_pending_rd;
    logic        md_timeout;
`ifdef STALL_STATS_EN
    logic [31:0] stat_load_use;
    logic [31:0] stat_md;
`endif

    int checks = 0;
    int passed = 0;
    logic last_stall;

    always #5 clock = ~clock;

    hazard_scoreboard dut (
        .clock(clock),
        .reset(reset),
        .fd_insn(fd_insn),
        .dx_insn(dx_insn),
        .dx_valid(dx_valid),
        .flush(flush),
        .md_ready(md_ready),
        .stall(stall),
        .md_busy(md_busy),
        .md_pending_rd(md_pending_rd),
        .md_timeout(md_timeout)
`ifdef STALL_STATS_EN
        ,
        .stat_load_use(stat_load_use),
        .stat_md(stat_md)
`endif
    );

    // Reference model state
    bit          m_busy;
    int          m_pend;
    int          m_age;
    bit          m_to;
    logic [31:0] m_slu;
    logic [31:0] m_smd;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'd0};
    endfunction

    function automatic bit m_is_md(input logic [31:0] insn);
        int op = int'(insn[31:27]);
        int alu = int'(insn[6:2]);
        return (op == 0) && (alu inside {6, 7});
    endfunction

    function automatic bit m_reads(input logic [31:0] insn, input int r, input bit lu_mode);
        int op = int'(insn[31:27]);
        int rd = int'(insn[26:22]);
        int rs = int'(insn[21:17]);
        int rt = int'(insn[16:12]);
        bit use_rs = op inside {0, 5, 8, 7, 2, 6};
        bit use_rt = (op == 0);
        bit use_rd = (op inside {7, 2, 6, 4}) && !(lu_mode && op == 7);
        if (r == 0) return 1'b0;
        return (use_rs && rs == r) || (use_rt && rt == r) || (use_rd && rd == r);
    endfunction

    function automatic int m_dest(input logic [31:0] insn);
        int op = int'(insn[31:27]);
        if (op inside {0, 5, 8}) return int'(insn[26:22]);
        if (op == 3) return 31;
        if (op == 21) return 30;
        return 0;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock cycle with the currently driven inputs; called at posedge+1.
    task automatic cycle();
        bit lu, mdh, exp_stall;
        int dxop = int'(dx_insn[31:27]);
        int dxrd = int'(dx_insn[26:22]);
        lu = dx_valid && dxop == 8 && dxrd != 0 && m_reads(fd_insn, dxrd, 1'b1);
        mdh = m_busy && (m_reads(fd_insn, m_pend, 1'b0) || m_dest(fd_insn) == m_pend || m_is_md(fd_insn));
        exp_stall = !reset && (lu || mdh);
        #3;
        last_stall = stall;
        check("stall", stall, exp_stall);
        @(posedge clock);
        #1;
        if (reset) begin
            m_busy = 0; m_pend = 0; m_age = 0; m_to = 0; m_slu = 0; m_smd = 0;
        end else begin
            if (lu) m_slu = m_slu + 32'd1;
            if (mdh) m_smd = m_smd + 32'd1;
            if (m_busy) begin
                if (md_ready) m_busy = 0;
                else if (m_age == MD_TIMEOUT - 1) begin m_busy = 0; m_to = 1; end
                else m_age++;
            end else if (dx_valid && !flush && !exp_stall && m_is_md(dx_insn) && dxrd != 0) begin
                m_busy = 1; m_pend = dxrd; m_age = 0;
            end
        end
        check("md_busy", md_busy, m_busy);
        check("md_timeout", md_timeout, m_to);
        if (m_busy) check("md_pending_rd", md_pending_rd, m_pend);
`ifdef STALL_STATS_EN
        check("stat_load_use", stat_load_use, m_slu);
        check("stat_md", stat_md, m_smd);
`endif
    endtask

    task automatic drive(input logic [31:0] fd, input logic [31:0] dx, input logic v,
                         input logic fl, input logic rdy, input logic rst);
        fd_insn = fd; dx_insn = dx; dx_valid = v; flush = fl; md_ready = rdy; reset = rst;
    endtask

    function automatic logic [4:0] rand_reg();
        int r = int'($urandom_range(0, 9));
        if (r > 7) r += 22;
        return 5'(r);
    endfunction

    function automatic logic [31:0] rand_insn();
        int ops[10] = '{0, 5, 8, 7, 2, 6, 4, 3, 21, 1};
        int alus[4] = '{0, 1, 6, 7};
        logic [4:0] op = 5'(ops[$urandom_range(0, 9)]);
        logic [4:0] alu = 5'(alus[$urandom_range(0, 3)]);
        return enc(op, rand_reg(), rand_reg(), rand_reg(), alu);
    endfunction

    typedef struct {
        logic [31:0] fd;
        logic [31:0] dx;
        logic        v;
        logic        exp;
    } lu_vec_t;

    localparam logic [31:0] LW_R3  = 32'h40C20000;
    localparam logic [31:0] ADD_T1 = 32'h01062000;
    localparam logic [31:0] MUL_R5 = 32'h014C7018;
    localparam logic [31:0] ADD_R8 = 32'h020A0000;
    localparam logic [31:0] ADD_R9 = 32'h02422000;

    initial begin
        lu_vec_t vecs[12];
        int n;
        vecs[0]  = '{ADD_T1, LW_R3, 1'b1, 1'b1};
        vecs[1]  = '{ADD_T1, LW_R3, 1'b0, 1'b0};
        vecs[2]  = '{enc(5'd7, 5'd3, 5'd1, 5'd0, 5'd0), LW_R3, 1'b1, 1'b0};
        vecs[3]  = '{enc(5'd7, 5'd4, 5'd3, 5'd0, 5'd0), LW_R3, 1'b1, 1'b1};
        vecs[4]  = '{enc(5'd2, 5'd3, 5'd1, 5'd0, 5'd0), LW_R3, 1'b1, 1'b1};
        vecs[5]  = '{enc(5'd4, 5'd3, 5'd0, 5'd0, 5'd0), LW_R3, 1'b1, 1'b1};
        vecs[6]  = '{enc(5'd5, 5'd4, 5'd1, 5'd3, 5'd0), LW_R3, 1'b1, 1'b0};
        vecs[7]  = '{enc(5'd0, 5'd4, 5'd1, 5'd3, 5'd0), LW_R3, 1'b1, 1'b1};
        vecs[8]  = '{enc(5'd0, 5'd4, 5'd0, 5'd0, 5'd0), enc(5'd8, 5'd0, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0};
        vecs[9]  = '{ADD_T1, enc(5'd5, 5'd3, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0};
        vecs[10] = '{enc(5'd0, 5'd3, 5'd1, 5'd2, 5'd0), LW_R3, 1'b1, 1'b0};
        vecs[11] = '{enc(5'd8, 5'd5, 5'd3, 5'd0, 5'd0), LW_R3, 1'b1, 1'b1};

        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        m_busy = 0; m_pend = 0; m_age = 0; m_to = 0; m_slu = 0; m_smd = 0;
        @(posedge clock);
        #1;
        cycle();
        check("reset_busy", md_busy, 0);
        check("reset_pend", md_pending_rd, 0);
        check("reset_timeout", md_timeout, 0);

        // T1 for one cycle, then T2 mult RAW
        drive(ADD_T1, LW_R3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t1_stall", last_stall, 1);
        drive(ADD_R8, MUL_R5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t2_issue_stall", last_stall, 0);
        check("t2_busy", md_busy, 1);
        check("t2_pend", md_pending_rd, 5);
        for (int k = 1; k <= 9; k++) begin
            drive(ADD_R8, 32'd0, 1'b0, 1'b0, (k == 9), 1'b0);
            cycle();
            check("t2_raw_stall", last_stall, 1);
        end
        check("t2_retired", md_busy, 0);
        drive(ADD_R8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t2_release", last_stall, 0);
`ifdef STALL_STATS_EN
        check("t6_stat_lu", stat_load_use, 1);
        check("t6_stat_md", stat_md, 9);
`endif

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].fd, vecs[i].dx, vecs[i].v, 1'b0, 1'b0, 1'b0);
            cycle();
            check($sformatf("lu_vec%0d", i), last_stall, vecs[i].exp);
        end

        // T3 independent / structural / WAW / flush-while-busy
        drive(32'd0, MUL_R5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(ADD_R9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t3_indep", last_stall, 0);
        drive(MUL_R5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t3_struct", last_stall, 1);
        drive(enc(5'd5, 5'd5, 5'd1, 5'd0, 5'd0), 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        check("t3_waw", last_stall, 1);
        check("t3_flush_keeps", md_busy, 1);
        drive(enc(5'd7, 5'd5, 5'd1, 5'd0, 5'd0), 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("t3_sw_raw", last_stall, 1);
        check("t3_retired", md_busy, 0);
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("ready_idle", md_busy, 0);

        // T4 flush blocks issue, then watchdog
        drive(32'd0, MUL_R5, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        check("t4_flush", md_busy, 0);
        drive(32'd0, MUL_R5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t4_issue", md_busy, 1);
        check("t4_no_timeout_yet", md_timeout, 0);
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (md_busy && n < 100) begin
            cycle();
            n++;
        end
        check("t4_busy_cycles", n, MD_TIMEOUT);
        check("t4_timeout", md_timeout, 1);

        // T5 reset while busy and stalling
        drive(32'd0, MUL_R5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(ADD_R8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t5_pre_stall", last_stall, 1);
        drive(ADD_R8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("t5_stall_in_reset", last_stall, 0);
        check("t5_busy", md_busy, 0);
        check("t5_pend", md_pending_rd, 0);
        check("t5_timeout", md_timeout, 0);

        for (int i = 0; i < 3000; i++) begin
            drive(rand_insn(), rand_insn(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) == 0));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
